uart_rx_fifo: RTL and testbench

Receive buffer directly downstream of the UART receiver. Captures each completed byte on the receiver's `rx_done` rising edge into a DEPTH-entry circular FIFO. Presents the bytes to the MCU bus side through a registered read handshake, with occupancy, threshold-interrupt and sticky-overflow status. Decouples the bit-level receiver from bus read latency so back-to-back frames are not lost.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_fifo_mem.sv | 56 +++++
 rtl/uart_rx_fifo.sv | 133 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared sizing constants and types for the UART receive path.
//             Supplies the default byte width, receive FIFO depth and
//             interrupt threshold, plus an occupancy-count type wide enough
//             to hold 0..RX_FIFO_DEPTH.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int RX_FIFO_DEPTH  = 16;
    localparam int RX_FIFO_THRESH = 8;

    // One extra bit so that "completely full" (== DEPTH) is representable.
    typedef logic [$clog2(RX_FIFO_DEPTH):0] fifo_cnt_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : uart_fifo_mem
//  Purpose  : DEPTH x DATA_W dual-port storage for the receive FIFO.
//             Synchronous write port; registered read port whose output
//             register updates only on a read enable and otherwise holds.
//  Ports    : clk, reset      - clock, asynchronous active-low reset
//             i_wr_en         - write strobe
//             i_wr_addr       - write address
//             i_wr_data       - write data
//             i_rd_en         - read strobe (loads the output register)
//             i_rd_addr       - read address
//             o_rd_data       - registered read data (reset to 0)
//  Revision : 1.0  initial release
// ============================================================================
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = RX_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [DATA_W-1:0]        o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Storage is deliberately not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read-before-write on an address collision: when the FIFO is full and
    // a push and pop land together, the pop must return the oldest byte,
    // which is exactly the value still in the array before this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : uart_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Receive buffer between the UART bit receiver and the MCU bus.
//             Captures one byte per rising edge of rx_done into a circular
//             FIFO and hands bytes out through a registered pop handshake,
//             with occupancy, level interrupt and sticky overflow status.
//  Ports    : clk           - system clock
//             reset         - asynchronous active-low reset
//             rx_done       - byte-complete strobe (may be several clks wide)
//             rx_data       - received byte, valid while rx_done is high
//             rd_en         - pop request
//             rd_data       - popped byte (registered, holds between pops)
//             rd_valid      - one-cycle pulse after an accepted pop
//             empty / full  - occupancy == 0 / == DEPTH
//             count         - occupancy 0..DEPTH
//             irq_level     - count >= THRESH
//             overflow      - sticky: a byte was dropped
//             clr_overflow  - clears overflow (a same-cycle drop wins)
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = RX_FIFO_DEPTH,
    parameter int THRESH = RX_FIFO_THRESH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_done,
    input  logic [DATA_W-1:0]      rx_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   irq_level,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] c_full_cnt   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_thresh_cnt = CNT_W'(THRESH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_rx_done_q;
    logic              r_rd_valid;
    logic              r_overflow;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_wr_accept;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_cnt);

    // One push per strobe, however long rx_done stays high.
    assign w_push = rx_done & ~r_rx_done_q;
    assign w_pop  = rd_en & ~w_empty;

    // A same-cycle pop frees the slot the push needs, so a full FIFO only
    // drops when nothing is being read out.
    assign w_wr_accept = w_push & (~w_full | w_pop);
    assign w_drop      = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            // Held high so a strobe already asserted at reset release is
            // not mistaken for a fresh byte.
            r_rx_done_q <= 1'b1;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_rx_done_q <= rx_done;
            r_rd_valid  <= w_pop;

            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end

            case ({w_wr_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (rx_data),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (rd_data)
    );

    assign rd_valid  = r_rd_valid;
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign irq_level = (r_count >= c_thresh_cnt);
    assign overflow  = r_overflow;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : Self-checking bench for uart_rx_fifo. A queue-based model
//             tracks the buffered bytes, the last popped byte and the sticky
//             overflow flag; every clock the DUT outputs are compared to it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int THRESH = 8;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_done;
    logic [DW-1:0] rx_data;
    logic          rd_en;
    logic          clr_overflow;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          irq_level;
    logic          overflow;

    uart_rx_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .THRESH (THRESH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done      (rx_done),
        .rx_data      (rx_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .irq_level    (irq_level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #10 clk = ~clk;

    // Reference model state
    logic [DW-1:0] m_q[$];
    bit            m_prev_rx;
    bit            m_ovf;
    logic [DW-1:0] m_rd;
    bit            m_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},    32'(count),     32'(m_q.size()));
        check({tag, ".empty"},    32'(empty),     32'(m_q.size() == 0));
        check({tag, ".full"},     32'(full),      32'(m_q.size() == DEPTH));
        check({tag, ".irq"},      32'(irq_level), 32'(m_q.size() >= THRESH));
        check({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
        check({tag, ".rd_valid"}, 32'(rd_valid),  32'(m_valid));
        check({tag, ".rd_data"},  32'(rd_data),   32'(m_rd));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_prev_rx = 1'b1;
        m_ovf     = 1'b0;
        m_rd      = '0;
        m_valid   = 1'b0;
    endtask

    // One clock: apply inputs, advance the model by the FIFO rules, compare.
    task automatic cyc(input bit rx, input logic [DW-1:0] d, input bit rd,
                       input bit clr, input string tag);
        bit push;
        bit pop;
        bit drop;
        rx_done      = rx;
        rx_data      = d;
        rd_en        = rd;
        clr_overflow = clr;
        @(posedge clk);
        push      = rx && !m_prev_rx;
        m_prev_rx = rx;
        pop       = rd && (m_q.size() != 0);
        m_valid   = pop;
        if (pop) m_rd = m_q.pop_front();
        drop = 1'b0;
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        check_all(tag);
    endtask

    task automatic push_byte(input logic [DW-1:0] d, input string tag);
        cyc(1'b1, d, 1'b0, 1'b0, tag);
        cyc(1'b0, d, 1'b0, 1'b0, tag);
    endtask

    task automatic pop_byte(input string tag);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 2; i++) pop_byte(tag);
    endtask

    initial begin
        // Reset with a strobe already high at release: must not be counted.
        reset        = 1'b0;
        rx_done      = 1'b1;
        rx_data      = 8'hEE;
        rd_en        = 1'b0;
        clr_overflow = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, "held_strobe");
        cyc(1'b0, 8'hEE, 1'b0, 1'b0, "held_strobe");

        // Three 4-cycle-wide strobes, then three single pops.
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++) cyc(1'b1, 8'(8'h41 + b), 1'b0, 1'b0, "wide_strobe");
            cyc(1'b0, 8'h00, 1'b0, 1'b0, "wide_strobe");
        end
        check("wide.count3", 32'(count), 32'd3);
        for (int b = 0; b < 3; b++) begin
            pop_byte("read3");
            check("read3.byte", 32'(rd_data), 32'(8'h41 + b));
            cyc(1'b0, 8'h00, 1'b0, 1'b0, "read3_gap");
        end
        check("read3.empty", 32'(empty), 32'd1);

        // Fill to full, then one overflowing push, then drain.
        for (int b = 0; b < DEPTH; b++) push_byte(8'(b), "fill");
        check("fill.full", 32'(full), 32'd1);
        push_byte(8'hAA, "overflow_push");
        check("ovf.flag", 32'(overflow), 32'd1);
        check("ovf.count", 32'(count), 32'(DEPTH));
        drain("drain_ovf");

        // Full FIFO with simultaneous push and pop: no overflow.
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "clr");
        for (int b = 0; b < DEPTH; b++) push_byte(8'(b), "fill2");
        cyc(1'b1, 8'h55, 1'b1, 1'b0, "full_push_pop");
        check("fpp.rd_data", 32'(rd_data), 32'h00);
        check("fpp.overflow", 32'(overflow), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, "fpp_gap");
        drain("drain_fpp");
        check("fpp.last", 32'(rd_data), 32'h55);

        // Empty FIFO with simultaneous push and pop: pop ignored.
        cyc(1'b1, 8'h7E, 1'b1, 1'b0, "empty_push_pop");
        check("epp.valid", 32'(rd_valid), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "epp_pop");
        check("epp.rd_data", 32'(rd_data), 32'h7E);

        // Clear racing an overflow: set wins, then clear alone.
        for (int b = 0; b < DEPTH; b++) push_byte(8'(8'h80 + b), "fill3");
        cyc(1'b1, 8'hBB, 1'b0, 1'b1, "clr_vs_drop");
        check("clr_vs_drop.ovf", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "clr_alone");
        check("clr_alone.ovf", 32'(overflow), 32'd0);
        drain("drain3");

        // Pointer wrap with interleaved push/pop pairs.
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'(i + 8'h10), 1'b0, 1'b0, "wrap_push");
            cyc(1'b0, 8'h00, 1'b1, 1'b0, "wrap_pop");
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 15) == 0), "random");
        end
        drain("drain_rand");
        cyc(1'b0, 8'h00, 1'b0, 1'b1, "clr2");

        // Mid-operation asynchronous reset with five bytes buffered.
        for (int b = 0; b < 5; b++) push_byte(8'(8'hC0 + b), "pre_reset");
        check("pre_reset.count", 32'(count), 32'd5);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b1, 1'b0, "post_reset");
        push_byte(8'h3C, "post_reset_push");
        pop_byte("post_reset_pop");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire
